// File: rtl/fdtd_pkg.sv
// Shared state encoding and default sizing for the FDTD field-read sequencer.
package fdtd_pkg;

  localparam int DEF_WORD_ADDR_WIDTH = 30;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_CNT_WIDTH       = 16;
  localparam int DEF_FIFO_DEPTH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fdtd_state_e;

endpackage

// File: rtl/fdtd_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; o_rd_data is the head entry whenever not empty.
module fdtd_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_push && !w_full;
  assign w_pop     = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst) !(i_push && w_full));

endmodule

// File: rtl/fdtd_field_rd_seq.sv
// FDTD field read sequencer: strided word-read sweep feeding a FWFT output buffer.
// state    | meaning
// ST_IDLE  | waiting for start_i; a zero-count start completes here
// ST_REQ   | issuing word reads, paced by free buffer entries
// ST_DRAIN | all words read; waiting for the buffer to empty
module fdtd_field_rd_seq
  import fdtd_pkg::*;
#(
  parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       start_i,
  input  logic [WORD_ADDR_WIDTH-1:0] base_word_addr_i,
  input  logic [WORD_ADDR_WIDTH-1:0] stride_i,
  input  logic [CNT_WIDTH-1:0]       count_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       rd_req_o,
  output logic [WORD_ADDR_WIDTH-1:0] rd_word_addr_o,
  input  logic [DATA_WIDTH-1:0]      rd_data_i,
  input  logic                       rd_gnt_i,
  output logic                       dout_valid_o,
  output logic [DATA_WIDTH-1:0]      dout_data_o,
  output logic                       dout_last_o,
  input  logic                       dout_ready_i
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  fdtd_state_e                r_state;
  fdtd_state_e                w_state_next;
  logic [WORD_ADDR_WIDTH-1:0] r_addr;
  logic [WORD_ADDR_WIDTH-1:0] r_stride;
  logic [CNT_WIDTH-1:0]       r_remaining;
  logic                       r_rd_req;
  logic                       r_done;

  logic                       w_accept;
  logic                       w_cnt_zero;
  logic                       w_grant;
  logic                       w_pop;
  logic [CNT_WIDTH-1:0]       w_rem_after;
  logic                       w_push_last;
  logic                       w_rd_req_next;
  logic                       w_done_next;
  logic                       w_empty;
  logic [OCC_W-1:0]           w_occ;
  logic [OCC_W-1:0]           w_occ_next;
  logic [DATA_WIDTH:0]        w_fifo_rd;

  assign w_accept    = (r_state == ST_IDLE) && start_i;
  assign w_cnt_zero  = (count_i == '0);
  // A grant only counts against an outstanding request.
  assign w_grant     = r_rd_req && rd_gnt_i;
  assign w_pop       = dout_valid_o && dout_ready_i;
  assign w_rem_after = w_grant ? (r_remaining - CNT_WIDTH'(1)) : r_remaining;
  assign w_push_last = (r_remaining == CNT_WIDTH'(1));
  assign w_occ_next  = w_occ + OCC_W'(w_grant) - OCC_W'(w_pop);

  fdtd_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (ACLK),
    .i_rst       (ARESET),
    .i_push      (w_grant),
    .i_push_data ({w_push_last, rd_data_i}),
    .i_pop       (w_pop),
    .o_rd_data   (w_fifo_rd),
    .o_empty     (w_empty),
    .o_count     (w_occ)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && !w_cnt_zero)        w_state_next = ST_REQ;
      ST_REQ:   if (w_grant && (w_rem_after == '0)) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_empty)                        w_state_next = ST_IDLE;
      default:                                      w_state_next = ST_IDLE;
    endcase
  end

  // A held request never loses its slot: occupancy cannot grow without a grant.
  always_comb begin
    busy_o        = (r_state != ST_IDLE);
    w_rd_req_next = 1'b0;
    w_done_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_cnt_zero) w_done_next   = 1'b1;
          else            w_rd_req_next = (w_occ_next < DEPTH_OCC);
        end
      end
      ST_REQ: begin
        w_rd_req_next = (r_rd_req && !rd_gnt_i) ||
                        ((w_rem_after != '0) && (w_occ_next < DEPTH_OCC));
      end
      ST_DRAIN: w_done_next = w_empty;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_addr      <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
      r_rd_req    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_req <= w_rd_req_next;
      r_done   <= w_done_next;
      if (w_accept && !w_cnt_zero) begin
        r_addr      <= base_word_addr_i;
        r_stride    <= stride_i;
        r_remaining <= count_i;
      end else if (w_grant) begin
        r_addr      <= r_addr + r_stride;
        r_remaining <= w_rem_after;
      end
    end
  end

  assign rd_req_o       = r_rd_req;
  assign rd_word_addr_o = r_addr;
  assign done_o         = r_done;
  assign dout_valid_o   = !w_empty;
  // Stale entries behind a flushed pointer must not show on the outputs.
  assign {dout_last_o, dout_data_o} = w_empty ? '0 : w_fifo_rd;

endmodule

// File: tb/tb_fdtd_field_rd_seq.sv
// Directed bench for fdtd_field_rd_seq with a small word-reader model and output logger.
module tb_fdtd_field_rd_seq;

  logic        ACLK;
  logic        ARESET;
  logic        start_i;
  logic [29:0] base_word_addr_i;
  logic [29:0] stride_i;
  logic [15:0] count_i;
  logic        busy_o;
  logic        done_o;
  logic        rd_req_o;
  logic [29:0] rd_word_addr_o;
  logic [31:0] rd_data_i;
  logic        rd_gnt_i;
  logic        dout_valid_o;
  logic [31:0] dout_data_o;
  logic        dout_last_o;
  logic        dout_ready_i;

  fdtd_field_rd_seq dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .start_i          (start_i),
    .base_word_addr_i (base_word_addr_i),
    .stride_i         (stride_i),
    .count_i          (count_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .rd_req_o         (rd_req_o),
    .rd_word_addr_o   (rd_word_addr_o),
    .rd_data_i        (rd_data_i),
    .rd_gnt_i         (rd_gnt_i),
    .dout_valid_o     (dout_valid_o),
    .dout_data_o      (dout_data_o),
    .dout_last_o      (dout_last_o),
    .dout_ready_i     (dout_ready_i)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [29:0] gnt_addr [64];
  logic [31:0] out_data [64];
  logic        out_last [64];
  int n_gnt, n_out, n_done, n_issued, wait_cnt, gnt_delay, gnt_limit;
  int hold_err, done_busy_err;
  bit busy_seen, spurious_pending;

  function automatic logic [31:0] rd_val(input logic [29:0] a);
    return {2'b01, a ^ 30'h0000_1555};
  endfunction

  task automatic reset_logs();
    n_gnt = 0; n_out = 0; n_done = 0; n_issued = 0; wait_cnt = 0;
    hold_err = 0; done_busy_err = 0; busy_seen = 0; spurious_pending = 0;
    gnt_limit = 1000;
  endtask

  // Log what the DUT acts on at the coming edge, then sample and drive the reader model.
  task automatic cycle();
    logic        p_rst, p_req, p_gnt;
    logic [29:0] p_addr;
    if (!ARESET && rd_req_o && rd_gnt_i && n_gnt < 64) begin
      gnt_addr[n_gnt] = rd_word_addr_o; n_gnt++;
    end
    if (!ARESET && dout_valid_o && dout_ready_i && n_out < 64) begin
      out_data[n_out] = dout_data_o; out_last[n_out] = dout_last_o; n_out++;
    end
    p_rst = ARESET; p_req = rd_req_o; p_gnt = rd_gnt_i; p_addr = rd_word_addr_o;
    @(posedge ACLK); #1;
    if (!p_rst && p_req && !p_gnt && (!rd_req_o || rd_word_addr_o !== p_addr)) hold_err++;
    if (done_o) n_done++;
    if (busy_o) busy_seen = 1;
    if (done_o && busy_o) done_busy_err++;
    rd_gnt_i = 1'b0;
    if (rd_req_o && n_issued < gnt_limit) begin
      wait_cnt++;
      if (wait_cnt > gnt_delay) begin
        rd_gnt_i = 1'b1; rd_data_i = rd_val(rd_word_addr_o); wait_cnt = 0; n_issued++;
      end
    end else if (!rd_req_o && busy_o && spurious_pending) begin
      rd_gnt_i = 1'b1; rd_data_i = 32'hDEAD_BEEF; spurious_pending = 0;
    end
  endtask

  task automatic start_sweep(input logic [29:0] b, input logic [29:0] s, input logic [15:0] c);
    base_word_addr_i = b; stride_i = s; count_i = c; start_i = 1'b1;
    cycle();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    while (n_done == 0 && k < budget) begin cycle(); k++; end
    ok = (n_done != 0);
    repeat (5) cycle();
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) cycle();
    tests_run++;
    if ({busy_o, done_o, rd_req_o, rd_word_addr_o, dout_valid_o, dout_data_o, dout_last_o} !== 67'h0) begin
      tests_failed++; $display("FAIL reset_outputs: got busy=%b done=%b req=%b addr=%0h valid=%b data=%0h last=%b, all required 0",
        busy_o, done_o, rd_req_o, rd_word_addr_o, dout_valid_o, dout_data_o, dout_last_o);
    end
    ARESET = 1'b0;
    repeat (2) cycle();
    tests_run++;
    if ({busy_o, done_o, rd_req_o, dout_valid_o} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_idle: got busy/done/req/valid=%b required 0000", {busy_o, done_o, rd_req_o, dout_valid_o});
    end
  endtask

  task automatic test_basic();
    logic [29:0] e;
    bit ok;
    reset_logs(); dout_ready_i = 1'b1; gnt_delay = 2;
    start_sweep(30'h100, 30'h1, 16'd3);
    tests_run++;
    if ({busy_o, rd_req_o, rd_word_addr_o} !== {2'b11, 30'h100}) begin
      tests_failed++; $display("FAIL basic_first_req: got busy=%b req=%b addr=%0h required 1 1 100", busy_o, rd_req_o, rd_word_addr_o);
    end
    wait_done(200, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL basic_timeout: done_o=0 after 200 cycles, required 1"); end
    tests_run++;
    if (n_gnt !== 3 || n_out !== 3 || n_done !== 1) begin
      tests_failed++; $display("FAIL basic_counts: got grants=%0d outs=%0d dones=%0d required 3 3 1", n_gnt, n_out, n_done);
    end
    e = 30'h100;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (gnt_addr[i] !== e || {out_last[i], out_data[i]} !== {(i == 2), rd_val(e)}) begin
        tests_failed++; $display("FAIL basic_word%0d: got addr=%0h data=%0h last=%b required %0h %0h %b",
          i, gnt_addr[i], out_data[i], out_last[i], e, rd_val(e), (i == 2));
      end
      e = e + 30'h1;
    end
    tests_run++;
    if (hold_err !== 0 || done_busy_err !== 0 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL basic_protocol: got hold_err=%0d done_busy_err=%0d busy=%b required 0 0 0", hold_err, done_busy_err, busy_o);
    end
  endtask

  task automatic test_backpressure();
    logic [29:0] e;
    bit ok;
    reset_logs(); dout_ready_i = 1'b0; gnt_delay = 0;
    start_sweep(30'h200, 30'h2, 16'd8);
    repeat (20) cycle();
    tests_run++;
    if (n_gnt !== 4 || rd_req_o !== 1'b0 || n_out !== 0 || dout_valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL bp_stall: got grants=%0d req=%b outs=%0d valid=%b required 4 0 0 1", n_gnt, rd_req_o, n_out, dout_valid_o);
    end
    dout_ready_i = 1'b1;
    wait_done(300, ok);
    tests_run++;
    if (!ok || n_gnt !== 8 || n_out !== 8 || n_done !== 1 || hold_err !== 0) begin
      tests_failed++; $display("FAIL bp_counts: got done_seen=%b grants=%0d outs=%0d dones=%0d hold_err=%0d required 1 8 8 1 0",
        ok, n_gnt, n_out, n_done, hold_err);
    end
    e = 30'h200;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (gnt_addr[i] !== e || {out_last[i], out_data[i]} !== {(i == 7), rd_val(e)}) begin
        tests_failed++; $display("FAIL bp_word%0d: got addr=%0h data=%0h last=%b required %0h %0h %b",
          i, gnt_addr[i], out_data[i], out_last[i], e, rd_val(e), (i == 7));
      end
      e = e + 30'h2;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    reset_logs(); dout_ready_i = 1'b1; gnt_delay = 1;
    start_sweep(30'h3FFF_FFFE, 30'h3, 16'd2);
    wait_done(200, ok);
    tests_run++;
    if (!ok || n_gnt !== 2 || n_out !== 2 || n_done !== 1) begin
      tests_failed++; $display("FAIL wrap_counts: got done_seen=%b grants=%0d outs=%0d dones=%0d required 1 2 2 1", ok, n_gnt, n_out, n_done);
    end
    tests_run++;
    if (gnt_addr[0] !== 30'h3FFF_FFFE || gnt_addr[1] !== 30'h0000_0001) begin
      tests_failed++; $display("FAIL wrap_addr: got %0h %0h required 3ffffffe 1", gnt_addr[0], gnt_addr[1]);
    end
    tests_run++;
    if ({out_last[0], out_data[0], out_last[1], out_data[1]} !== {1'b0, rd_val(30'h3FFF_FFFE), 1'b1, rd_val(30'h1)}) begin
      tests_failed++; $display("FAIL wrap_data: got %0h/%b %0h/%b required %0h/0 %0h/1",
        out_data[0], out_last[0], out_data[1], out_last[1], rd_val(30'h3FFF_FFFE), rd_val(30'h1));
    end
  endtask

  task automatic test_count_zero();
    reset_logs(); dout_ready_i = 1'b1; gnt_delay = 0;
    start_sweep(30'h55, 30'h1, 16'd0);
    tests_run++;
    if ({done_o, rd_req_o, busy_o} !== 3'b100) begin
      tests_failed++; $display("FAIL zero_next_cycle: got done/req/busy=%b required 100", {done_o, rd_req_o, busy_o});
    end
    cycle();
    tests_run++;
    if (done_o !== 1'b0) begin tests_failed++; $display("FAIL zero_done_width: got done=%b required 0", done_o); end
    repeat (5) cycle();
    tests_run++;
    if (n_done !== 1 || n_gnt !== 0 || busy_seen !== 1'b0) begin
      tests_failed++; $display("FAIL zero_quiet: got dones=%0d grants=%0d busy_seen=%b required 1 0 0", n_done, n_gnt, busy_seen);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    reset_logs(); dout_ready_i = 1'b0; gnt_delay = 0; gnt_limit = 2;
    start_sweep(30'h300, 30'h1, 16'd6);
    repeat (4) cycle();
    tests_run++;
    if ({rd_req_o, dout_valid_o, rd_word_addr_o} !== {2'b11, 30'h302} || n_issued !== 2) begin
      tests_failed++; $display("FAIL abort_setup: got req=%b valid=%b addr=%0h issued=%0d required 1 1 302 2",
        rd_req_o, dout_valid_o, rd_word_addr_o, n_issued);
    end
    ARESET = 1'b1;
    cycle();
    tests_run++;
    if ({busy_o, done_o, rd_req_o, rd_word_addr_o, dout_valid_o, dout_data_o, dout_last_o} !== 67'h0) begin
      tests_failed++; $display("FAIL abort_outputs: got busy=%b done=%b req=%b addr=%0h valid=%b data=%0h last=%b, all required 0",
        busy_o, done_o, rd_req_o, rd_word_addr_o, dout_valid_o, dout_data_o, dout_last_o);
    end
    ARESET = 1'b0;
    repeat (3) cycle();
    tests_run++;
    if (n_done !== 0 || dout_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL abort_no_done: got dones=%0d valid=%b required 0 0", n_done, dout_valid_o);
    end
    reset_logs(); dout_ready_i = 1'b1; gnt_delay = 1;
    start_sweep(30'h10, 30'h4, 16'd2);
    wait_done(200, ok);
    tests_run++;
    if (!ok || n_gnt !== 2 || n_out !== 2 || n_done !== 1 ||
        gnt_addr[0] !== 30'h10 || gnt_addr[1] !== 30'h14 ||
        {out_last[0], out_data[0], out_last[1], out_data[1]} !== {1'b0, rd_val(30'h10), 1'b1, rd_val(30'h14)}) begin
      tests_failed++; $display("FAIL abort_resweep: got grants=%0d outs=%0d dones=%0d addr=%0h,%0h data=%0h/%b,%0h/%b required 2 2 1 10,14 %0h/0,%0h/1",
        n_gnt, n_out, n_done, gnt_addr[0], gnt_addr[1], out_data[0], out_last[0], out_data[1], out_last[1], rd_val(30'h10), rd_val(30'h14));
    end
  endtask

  task automatic test_ignored_inputs();
    logic [29:0] e;
    bit ok;
    reset_logs(); dout_ready_i = 1'b1; gnt_delay = 3; spurious_pending = 1;
    start_sweep(30'h40, 30'h5, 16'd4);
    repeat (2) cycle();
    base_word_addr_i = 30'h0; stride_i = 30'h1; count_i = 16'd9; start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    wait_done(300, ok);
    tests_run++;
    if (!ok || n_gnt !== 4 || n_out !== 4 || n_done !== 1 || spurious_pending !== 1'b0 || hold_err !== 0) begin
      tests_failed++; $display("FAIL ignore_counts: got done_seen=%b grants=%0d outs=%0d dones=%0d spurious_left=%b hold_err=%0d required 1 4 4 1 0 0",
        ok, n_gnt, n_out, n_done, spurious_pending, hold_err);
    end
    e = 30'h40;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (gnt_addr[i] !== e || {out_last[i], out_data[i]} !== {(i == 3), rd_val(e)}) begin
        tests_failed++; $display("FAIL ignore_word%0d: got addr=%0h data=%0h last=%b required %0h %0h %b",
          i, gnt_addr[i], out_data[i], out_last[i], e, rd_val(e), (i == 3));
      end
      e = e + 30'h5;
    end
  endtask

  initial begin
    ARESET = 1'b1; start_i = 1'b0; base_word_addr_i = '0; stride_i = '0; count_i = '0;
    rd_data_i = '0; rd_gnt_i = 1'b0; dout_ready_i = 1'b0; gnt_delay = 0;
    reset_logs();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_count_zero();
    test_reset_abort();
    test_ignored_inputs();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required finish");
    $fatal(1);
  end

endmodule
